// File: rtl/uart_receiver_if.sv
// Receive-side bundle between the serial line / baud generator and the uart_receiver.
// The slave modport is the receiver itself; master is the line driver and Rx FIFO side.
interface uart_receiver_if #(
    parameter int DBITS = 8
);
    logic             rx;
    logic             sample_tick;
    logic [DBITS-1:0] data_out;
    logic             rx_done;
    logic             frame_err;
    logic             parity_err;

    modport master (
        output rx,
        output sample_tick,
        input  data_out,
        input  rx_done,
        input  frame_err,
        input  parity_err
    );

    modport slave (
        input  rx,
        input  sample_tick,
        output data_out,
        output rx_done,
        output frame_err,
        output parity_err
    );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start-bit validation, mid-bit data sampling (LSB first),
// optional parity and stop-bit checks, one-cycle rx_done strobe into the Rx FIFO.
module uart_receiver #(
    parameter int DBITS      = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic           clk_100MHz,
    input  logic           reset,
    uart_receiver_if.slave rx_if
);

    localparam int TW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(SB_TICK / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SB_TICK - 1);
    localparam logic [NW-1:0] NB_LAST   = NW'(DBITS - 1);
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);
    localparam logic          PAR_ON    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [NW-1:0]    nbits_q, nbits_d;
    logic [DBITS-1:0] shreg_q, shreg_d;
    logic             perr_q, perr_d;
    logic [DBITS-1:0] data_out_q, data_out_d;
    logic             rx_done_q, rx_done_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;

    logic rx_meta_q;
    logic rx_s_q;
    logic sample_tick;

    assign sample_tick = rx_if.sample_tick;

    // rx is asynchronous to the clock; idle-high reset value avoids a false start after reset.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_if.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            nbits_q      <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            nbits_q      <= nbits_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        nbits_d      = nbits_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        rx_done_d    = 1'b0;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;

        case (state_q)
            // Leaving idle needs no tick, so the falling-edge tick itself is never counted.
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    tick_d  = '0;
                end
            end

            ST_START: begin
                if (sample_tick) begin
                    if (tick_q == TICK_MID) begin
                        if (!rx_s_q) begin
                            state_d = ST_DATA;
                            tick_d  = '0;
                            nbits_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (sample_tick) begin
                    if (tick_q == TICK_LAST) begin
                        shreg_d = {rx_s_q, shreg_q[DBITS-1:1]};
                        tick_d  = '0;
                        if (nbits_q == NB_LAST) begin
                            state_d = PAR_ON ? ST_PARITY : ST_STOP;
                        end else begin
                            nbits_d = nbits_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (sample_tick) begin
                    if (tick_q == TICK_LAST) begin
                        perr_d  = rx_s_q ^ (^shreg_q) ^ ODD_BIT;
                        tick_d  = '0;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            // Stop is judged at mid-bit, so idle is re-entered half a bit early.
            ST_STOP: begin
                if (sample_tick) begin
                    if (tick_q == TICK_LAST) begin
                        state_d      = ST_IDLE;
                        data_out_d   = shreg_q;
                        frame_err_d  = ~rx_s_q;
                        parity_err_d = PAR_ON ? perr_q : 1'b0;
                        rx_done_d    = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_if.data_out   = data_out_q;
    assign rx_if.rx_done    = rx_done_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.parity_err = parity_err_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the team's uart_transmitter.
- Oversamples the rx line using sample_tick from the shared baud rate generator (SB_TICK ticks per bit).
- Detects and validates the start bit, samples each data bit at mid-bit (LSB first), and checks optional parity and the stop bit.
- Hands the received word to the Rx FIFO with a one-cycle rx_done write strobe.

Parameters:
- DBITS, 8, number of data bits per frame (5..8).
- SB_TICK, 16, sample ticks per bit; must be even and >= 4.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity expected, 0 = even; ignored when PARITY_EN = 0.

Ports:
- clk_100MHz  input  1  system clock (Basys3 100 MHz).
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial receive line, asynchronous to the clock, idle high.
- sample_tick  input  1  one-cycle oversampling strobe from the baud rate generator.
- data_out  output  DBITS  last received word; goes to the Rx FIFO write data.
- rx_done  output  1  one-cycle pulse when a frame completes; FIFO write enable.
- frame_err  output  1  stop bit sampled low in the last frame.
- parity_err  output  1  parity mismatch in the last frame; always 0 when PARITY_EN = 0.

Behaviour:

Input synchroniser and registers
- rx passes through a 2-FF synchroniser; both flops reset to 1. All decisions use the synchronised value rx_s (2-cycle latency).
- All state, counters and outputs are flopped on clk_100MHz with asynchronous reset.
- Reset values: state = idle, tick/nbits = 0, shift register = 0, data_out = 0, rx_done = 0, frame_err = 0, parity_err = 0.
- Reset mid-frame aborts the frame immediately; no rx_done is produced for it.

Tick counter
- Width ceil(log2(SB_TICK)); 4 bits at the default.
- Increments only on sample_tick. Cycles without sample_tick hold all counters.

States
- idle: when rx_s == 0, go to start and clear tick. sample_tick is not required to leave idle.
- start: on sample_tick, when tick == SB_TICK/2-1 (mid start bit):
  - rx_s == 0: go to data, clear tick and nbits.
  - rx_s == 1: glitch; return to idle with no output change.
  - Otherwise tick + 1.
- data: on sample_tick, when tick == SB_TICK-1:
  - Shift right: shreg = {rx_s, shreg[DBITS-1:1]}, so the LSB is received first. Clear tick.
  - If nbits == DBITS-1, go to parity (PARITY_EN = 1) or stop; otherwise nbits + 1.
  - Otherwise tick + 1.
- parity: on sample_tick, when tick == SB_TICK-1:
  - Latch perr = rx_s XOR (^shreg) XOR PARITY_ODD. Clear tick and go to stop.
- stop: on sample_tick, when tick == SB_TICK-1, go to idle and in that same edge:
  - data_out <= shreg.
  - frame_err <= ~rx_s.
  - parity_err <= perr (0 if parity disabled).
  - rx_done <= 1.

Output timing
- rx_done is high for exactly one cycle, in the cycle after the final stop-bit tick edge. data_out and both error flags are valid in that cycle and held until the next rx_done.
- A frame with frame_err = 1 is still delivered (rx_done pulses); the consumer decides whether to drop it.
- Since the stop bit is sampled at mid-bit, idle is re-entered half a bit early. A start edge immediately after the stop bit is accepted; back-to-back frames lose nothing.
- rx held low permanently (break): every frame gives data_out = 0 and frame_err = 1, and the receiver re-enters start immediately after each one.
- sample_tick coinciding with the rx_s falling edge in idle is not counted; counting begins on the next tick.

Test Plan:
- Defaults, sample_tick every 4 clocks, send 0x55 (8N1) -> exactly one rx_done pulse; data_out = 0x55, frame_err = 0, parity_err = 0; state returns to idle.
- Back-to-back frames 0xA3 then 0x0F with no idle gap -> two rx_done pulses, data_out = 0xA3 then 0x0F, no errors.
- rx low for 5 sample ticks, then high (glitch shorter than SB_TICK/2) -> no rx_done; receiver back in idle; a following 0x3C is received correctly.
- Send 0x81 with stop bit driven 0 -> rx_done pulses, data_out = 0x81, frame_err = 1.
- PARITY_EN = 1, PARITY_ODD = 0, send 0x07 with parity bit 1 -> parity_err = 0. Repeat with parity bit 0 -> parity_err = 1.
- Assert reset during data bit 4 of a frame, release, then send 0xC6 -> no rx_done for the aborted frame; all outputs read 0 after reset; 0xC6 received cleanly.
